// File: rtl/gate_checker_pkg.sv
// Shared encodings for the gate checker: gate selections, FSM states, counter width.
// No logic here; latency and backpressure do not apply.
package gate_checker_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        SEL_AND  = 3'd0,
        SEL_OR   = 3'd1,
        SEL_NAND = 3'd2,
        SEL_NOR  = 3'd3,
        SEL_XOR  = 3'd4,
        SEL_XNOR = 3'd5,
        SEL_RSV6 = 3'd6,
        SEL_RSV7 = 3'd7
    } gate_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Golden two-input gate: expected output for (sel, in1, in2), plus an illegal-selection flag.
// Purely combinational, zero latency, no flow control.
module gate_ref_model
    import gate_checker_pkg::*;
(
    input  logic [2:0] i_sel,
    input  logic       i_in1,
    input  logic       i_in2,
    output logic       o_expected,
    output logic       o_illegal
);

    always_comb begin
        o_expected = 1'b0;
        o_illegal  = 1'b0;
        case (gate_sel_e'(i_sel))
            SEL_AND:  o_expected =   i_in1 & i_in2;
            SEL_OR:   o_expected =   i_in1 | i_in2;
            SEL_NAND: o_expected = ~(i_in1 & i_in2);
            SEL_NOR:  o_expected = ~(i_in1 | i_in2);
            SEL_XOR:  o_expected =   i_in1 ^ i_in2;
            SEL_XNOR: o_expected = ~(i_in1 ^ i_in2);
            default:  o_illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_checker.sv
// Checks observed samples of a 2-input gate against a reference until all four input combinations are seen.
// Sample results register on the sampling edge; no backpressure, every valid sample in CHECK is consumed.
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_gate_sel,
    input  logic             i_valid,
    input  logic             i_in1,
    input  logic             i_in2,
    input  logic             i_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_sel_err,
    output logic [3:0]       o_cover,
    output logic [CNT_W-1:0] o_pass_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [2:0]       o_fail_vec,
    output logic             o_fail_seen
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_sel;
    logic             r_sel_err;
    logic [3:0]       r_cover;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [2:0]       r_fail_vec;
    logic             r_fail_seen;

    logic             w_in_check;
    logic             w_start_ok;
    logic             w_sample;
    logic [2:0]       w_sel;
    logic             w_expected;
    logic             w_illegal;
    logic             w_match;
    logic [3:0]       w_cover_nxt;

    assign w_in_check  = (r_state == ST_CHECK);
    assign w_start_ok  = i_start && !w_in_check;
    assign w_sample    = i_valid && w_in_check;
    // Outside CHECK the model sees the incoming selection so an illegal one is caught on the start edge.
    assign w_sel       = w_in_check ? r_sel : i_gate_sel;
    assign w_match     = (i_out == w_expected);
    assign w_cover_nxt = r_cover | (4'b0001 << {i_in1, i_in2});

    gate_ref_model u_ref (
        .i_sel      (w_sel),
        .i_in1      (i_in1),
        .i_in2      (i_in2),
        .o_expected (w_expected),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = w_illegal ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_valid && (w_cover_nxt == 4'b1111)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == ST_CHECK);
        o_done = (r_state == ST_DONE);
        o_pass = (r_state == ST_DONE) && (r_err_cnt == '0) && !r_sel_err;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel       <= 3'd0;
            r_sel_err   <= 1'b0;
            r_cover     <= 4'b0000;
            r_pass_cnt  <= '0;
            r_err_cnt   <= '0;
            r_fail_vec  <= 3'b000;
            r_fail_seen <= 1'b0;
        end else if (w_start_ok) begin
            r_sel       <= i_gate_sel;
            r_sel_err   <= w_illegal;
            r_cover     <= 4'b0000;
            r_pass_cnt  <= '0;
            r_err_cnt   <= '0;
            r_fail_vec  <= 3'b000;
            r_fail_seen <= 1'b0;
        end else if (w_sample) begin
            r_cover <= w_cover_nxt;
            if (w_match) begin
                if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
            end else begin
                if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_fail_seen) begin
                    r_fail_vec  <= {i_in1, i_in2, i_out};
                    r_fail_seen <= 1'b1;
                end
            end
        end
    end

    assign o_sel_err    = r_sel_err;
    assign o_cover      = r_cover;
    assign o_pass_count = r_pass_cnt;
    assign o_err_count  = r_err_cnt;
    assign o_fail_vec   = r_fail_vec;
    assign o_fail_seen  = r_fail_seen;

endmodule

// File: tb/tb_gate_checker.sv
// Directed scenarios for gate_checker; expected snapshots queued by the driver, compared by a monitor.
module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       valid = 1'b0;
    logic       in1 = 1'b0;
    logic       in2 = 1'b0;
    logic       out = 1'b0;

    logic       busy, done, pass, sel_err, fail_seen;
    logic [3:0] cov;
    logic [7:0] pass_count, err_count;
    logic [2:0] fail_vec;

    always #5 clk = ~clk;

    gate_checker #(.CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_gate_sel   (gate_sel),
        .i_valid      (valid),
        .i_in1        (in1),
        .i_in2        (in2),
        .i_out        (out),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_sel_err    (sel_err),
        .o_cover      (cov),
        .o_pass_count (pass_count),
        .o_err_count  (err_count),
        .o_fail_vec   (fail_vec),
        .o_fail_seen  (fail_seen)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic       sel_err;
        logic [3:0] cov;
        logic [7:0] pc;
        logic [7:0] ec;
        logic [2:0] fv;
        logic       fs;
    } snap_t;

    snap_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic snap_t mk(input logic b, input logic d, input logic p, input logic se,
                                 input logic [3:0] cv, input logic [7:0] pc, input logic [7:0] ec,
                                 input logic [2:0] fv, input logic fs);
        snap_t s;
        s.busy = b; s.done = d; s.pass = p; s.sel_err = se;
        s.cov = cv; s.pc = pc; s.ec = ec; s.fv = fv; s.fs = fs;
        return s;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (snapshot %0d): got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: one queued snapshot per clock, compared mid-cycle.
    snap_t ex;
    int    snap_idx = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                ex = q.pop_front();
                chk("busy",       snap_idx, {7'd0, busy},      {7'd0, ex.busy});
                chk("done",       snap_idx, {7'd0, done},      {7'd0, ex.done});
                chk("pass",       snap_idx, {7'd0, pass},      {7'd0, ex.pass});
                chk("sel_err",    snap_idx, {7'd0, sel_err},   {7'd0, ex.sel_err});
                chk("cover",      snap_idx, {4'd0, cov},       {4'd0, ex.cov});
                chk("pass_count", snap_idx, pass_count,        ex.pc);
                chk("err_count",  snap_idx, err_count,         ex.ec);
                chk("fail_vec",   snap_idx, {5'd0, fail_vec},  {5'd0, ex.fv});
                chk("fail_seen",  snap_idx, {7'd0, fail_seen}, {7'd0, ex.fs});
                snap_idx++;
            end
        end
    end

    // Called at a falling edge; applies inputs across one rising edge and queues the expected result.
    task automatic step(input logic st, input logic [2:0] sel, input logic v,
                        input logic a, input logic b, input logic o, input snap_t e);
        start = st; gate_sel = sel; valid = v; in1 = a; in2 = b; out = o;
        @(posedge clk);
        #1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
    endtask

    task automatic smp(input logic a, input logic b, input logic o, input snap_t e);
        step(1'b0, 3'd0, 1'b1, a, b, o, e);
    endtask

    // Reset asserted just after a rising edge; outputs must clear before the next edge.
    task automatic rst_mid();
        start = 1'b0; valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.push_back('0);
        @(negedge clk);
    endtask

    snap_t z = '0;

    initial begin
        @(negedge clk);
        // Held in reset, even a start is ignored.
        step(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, z);
        rst_n = 1'b1;

        // Scenario 1: AND, all correct; first start after reset honoured immediately.
        step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1,0,0,0,4'b0000,8'd0,8'd0,3'b000,0));
        smp(0,0,0, mk(1,0,0,0,4'b0001,8'd1,8'd0,3'b000,0));
        smp(0,1,0, mk(1,0,0,0,4'b0011,8'd2,8'd0,3'b000,0));
        smp(1,0,0, mk(1,0,0,0,4'b0111,8'd3,8'd0,3'b000,0));
        smp(1,1,1, mk(0,1,1,0,4'b1111,8'd4,8'd0,3'b000,0));
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0,1,1,0,4'b1111,8'd4,8'd0,3'b000,0));

        // Scenario 2: XOR with two bad samples; trailing sample after DONE ignored.
        step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, mk(1,0,0,0,4'b0000,8'd0,8'd0,3'b000,0));
        smp(0,0,0, mk(1,0,0,0,4'b0001,8'd1,8'd0,3'b000,0));
        smp(0,1,0, mk(1,0,0,0,4'b0011,8'd1,8'd1,3'b010,1));
        smp(1,0,1, mk(1,0,0,0,4'b0111,8'd2,8'd1,3'b010,1));
        smp(1,1,1, mk(0,1,0,0,4'b1111,8'd2,8'd2,3'b010,1));
        smp(1,1,0, mk(0,1,0,0,4'b1111,8'd2,8'd2,3'b010,1));

        // Scenario 3: illegal selection goes straight to DONE.
        step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, mk(0,1,0,1,4'b0000,8'd0,8'd0,3'b000,0));
        smp(0,0,1, mk(0,1,0,1,4'b0000,8'd0,8'd0,3'b000,0));

        // Scenarios 4 and 6: OR saturation, with a start pulse mid-run that must be ignored.
        step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1,0,0,0,4'b0000,8'd0,8'd0,3'b000,0));
        for (int i = 0; i < 300; i++) begin
            logic [7:0] pc;
            pc = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            if (i == 100)
                step(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, mk(1,0,0,0,4'b1000,pc,8'd0,3'b000,0));
            else
                smp(1,1,1, mk(1,0,0,0,4'b1000,pc,8'd0,3'b000,0));
        end

        // Scenario 5: reset mid-run, then a fresh NAND run.
        rst_mid();
        step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, z);
        rst_n = 1'b1;
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(1,0,0,0,4'b0000,8'd0,8'd0,3'b000,0));
        smp(0,0,1, mk(1,0,0,0,4'b0001,8'd1,8'd0,3'b000,0));
        smp(0,1,0, mk(1,0,0,0,4'b0011,8'd1,8'd1,3'b010,1));
        rst_mid();
        rst_n = 1'b1;
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(1,0,0,0,4'b0000,8'd0,8'd0,3'b000,0));
        smp(0,0,1, mk(1,0,0,0,4'b0001,8'd1,8'd0,3'b000,0));
        smp(0,1,1, mk(1,0,0,0,4'b0011,8'd2,8'd0,3'b000,0));
        smp(1,0,1, mk(1,0,0,0,4'b0111,8'd3,8'd0,3'b000,0));
        smp(1,1,0, mk(0,1,1,0,4'b1111,8'd4,8'd0,3'b000,0));

        for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d snapshots left unchecked, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the pass and error counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a check run.
REQ-005 gate_sel  input  3  function under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 illegal.
REQ-006 valid  input  1  qualifies in1/in2/out as one observed sample.
REQ-007 in1  input  1  first gate input, as applied to the DUT.
REQ-008 in2  input  1  second gate input, as applied to the DUT.
REQ-009 out  input  1  DUT output being checked.
REQ-010 busy  output  1  high while in CHECK.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  in DONE: high when err_count==0 and sel_err==0; otherwise low.
REQ-013 sel_err  output  1  illegal gate_sel latched at start.
REQ-014 cover  output  4  bit {in1,in2} set once that input combination has been sampled.
REQ-015 pass_count  output  CNT_W  matching samples.
REQ-016 err_count  output  CNT_W  mismatching samples.
REQ-017 fail_vec  output  3  {in1,in2,out} of the first mismatch.
REQ-018 fail_seen  output  1  fail_vec is valid.

Function
REQ-019 FSM SHALL have exactly three states: IDLE, CHECK and DONE.
REQ-020 In IDLE or DONE, start SHALL latch gate_sel, clear cover, counters, fail_vec, fail_seen and sel_err, and enter CHECK on that edge.
REQ-021 If the latched gate_sel is 6 or 7, the FSM SHALL set sel_err and go to DONE instead of CHECK, with pass=0.
REQ-022 start in CHECK SHALL be ignored.
REQ-023 valid in IDLE or DONE SHALL be ignored, with no counter or cover change.
REQ-024 In CHECK, on an edge with valid=1, the expected output SHALL be computed from the latched selection and in1/in2.
REQ-025 A sample matching the expected output SHALL increment pass_count; a mismatch SHALL increment err_count.
REQ-026 Every sample in CHECK SHALL set cover[{in1,in2}].
REQ-027 All sample updates SHALL be registered on the sampling edge, with zero further latency.
REQ-028 On the first mismatch, fail_vec SHALL capture {in1,in2,out} and fail_seen SHALL set; later mismatches SHALL not overwrite fail_vec.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 On the edge where cover becomes 4'b1111, the FSM SHALL enter DONE; that sample SHALL still be counted.
REQ-031 Repeated samples of an already-covered combination SHALL be counted and SHALL not end the run.
REQ-032 In DONE, all outputs SHALL hold until the next start or reset.
REQ-033 X or Z on in1/in2/out when valid=1 is out of scope.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and set every output to 0, including cover, both counters and fail_vec.
REQ-035 Reset asserted mid-run SHALL discard the run; no partial result SHALL remain visible after release.
REQ-036 The first start after rst_n deasserts SHALL be honoured on the first rising edge.

Structure
REQ-037 Package gate_checker_pkg SHALL hold the gate_sel encodings, the state encoding and the CNT_W default.
REQ-038 Sub-module gate_ref_model SHALL be purely combinational: (sel, in1, in2) -> expected, plus an illegal flag.
REQ-039 gate_checker SHALL instantiate gate_ref_model exactly once.
REQ-040 Target implementation size is roughly 150-250 lines of RTL in total.

Verification
REQ-041 Scenario 1: sel=0 (AND); samples 00/0, 01/0, 10/0, 11/1 -> done=1 after the 4th edge, pass=1, pass_count=4, err_count=0, cover=1111.
REQ-042 Scenario 2: sel=4 (XOR); samples 00/0, 01/0 (bad), 10/1, 11/1 (bad), 11/0 -> done after the 4th sample, err_count=2, fail_vec=3'b010, pass=0, 5th sample ignored.
REQ-043 Scenario 3: sel=7 with start -> next edge done=1, sel_err=1, pass=0, busy never high.
REQ-044 Scenario 4: sel=1 (OR); 300 samples of 11/1, CNT_W=8 -> pass_count saturates at 255, busy stays 1, cover=1000.
REQ-045 Scenario 5: rst_n low after 2 samples -> all outputs 0 immediately; new start with sel=2 completes a fresh run with pass_count=4.
REQ-046 Scenario 6: start pulse in the middle of CHECK -> no clear of counters or cover, run continues.
